// File: rtl/fifo_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sdp_ram
//  Description : Simple dual-port RAM. It has one write port and one
//                registered read port, and no reset. Shared by the FIFOs
//                in this codebase.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sdp_ram #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Synchronous write and registered read. The contents are never reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        o_rdata <= mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/fwft_fifo_lvl.sv
`default_nettype none
// ============================================================================
//  Module      : fwft_fifo_lvl
//  Description : First-word-fall-through synchronous FIFO. It has an
//                occupancy count, almost-full and almost-empty thresholds,
//                overflow and underflow pulses, and accepts a write while
//                full if a read happens in the same cycle. The head word sits
//                in an output register. The remaining words are kept in a
//                RAM that is read one cycle ahead.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwft_fifo_lvl #(
    parameter int DWIDTH    = 32,
    parameter int DEPTH     = 16,
    parameter int AWIDTH    = $clog2(DEPTH),
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [DWIDTH-1:0] din,
    input  logic              read,
    output logic [DWIDTH-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AWIDTH:0] C_DEPTH   = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] C_ONE     = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0] C_AFULL   = (AWIDTH+1)'(AFULL_TH);
    localparam logic [AWIDTH:0] C_AEMPTY  = (AWIDTH+1)'(AEMPTY_TH);
    localparam logic            C_AF_RST  = (AFULL_TH == 0) ? 1'b1 : 1'b0;

    // Reject illegal parameter values at elaboration time.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("fwft_fifo_lvl: DEPTH must be a power of two >= 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_chk_afull
        $error("fwft_fifo_lvl: AFULL_TH out of range 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_chk_aempty
        $error("fwft_fifo_lvl: AEMPTY_TH out of range 0..DEPTH-1");
    end

    logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic [DWIDTH-1:0] head_q, head_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic [DWIDTH-1:0] fwd_data_q, fwd_data_d;

    logic              ren, wen;
    logic              head_take, ram_has_data;
    logic              load_ram, load_bypass, ram_we;
    logic [DWIDTH-1:0] ram_rdata, prefetch;

    // The RAM is DEPTH deep so that it wraps on power-of-two pointers.
    // Capacity is still bounded by count: it holds at most DEPTH-1 words
    // behind the head register.
    fifo_sdp_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (ram_we),
        .i_waddr (wr_ptr_q[AWIDTH-1:0]),
        .i_wdata (din),
        .i_raddr (rd_ptr_d[AWIDTH-1:0]),
        .o_rdata (ram_rdata)
    );

    // Accept logic, head load selection, pointer and flag next-state.
    always_comb begin
        ren          = read & ~empty_q;
        wen          = write & (~full_q | read);
        // The head is valid whenever count is non-zero. The RAM holds count-1.
        head_take    = empty_q | ren;
        ram_has_data = (count_q > C_ONE);
        load_ram     = head_take & ram_has_data;
        load_bypass  = head_take & ~ram_has_data & wen;
        ram_we       = wen & ~load_bypass;

        // A word written in the previous cycle to the address being read
        // ahead is not visible in the registered RAM output yet. Use the
        // forwarded copy in that case.
        prefetch     = fwd_valid_q ? fwd_data_q : ram_rdata;

        head_d       = head_q;
        if (load_ram) begin
            head_d = prefetch;
        end else if (load_bypass) begin
            head_d = din;
        end

        wr_ptr_d     = wr_ptr_q + {{AWIDTH{1'b0}}, ram_we};
        rd_ptr_d     = rd_ptr_q + {{AWIDTH{1'b0}}, load_ram};

        // The RAM write address equals the next read-ahead address only
        // when the RAM is otherwise empty, so the written word is next.
        fwd_valid_d  = ram_we && (wr_ptr_q[AWIDTH-1:0] == rd_ptr_d[AWIDTH-1:0]);
        fwd_data_d   = din;

        count_d      = count_q + {{AWIDTH{1'b0}}, wen} - {{AWIDTH{1'b0}}, ren};
        full_d       = (count_d == C_DEPTH);
        empty_d      = (count_d == '0);
        afull_d      = (count_d >= C_AFULL);
        aempty_d     = (count_d <= C_AEMPTY);
        ovf_d        = write & full_q & ~read;
        udf_d        = read & empty_q;
    end

    // State register. The asynchronous reset flushes everything except the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= C_AF_RST;
            aempty_q    <= 1'b1;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign dout         = head_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_fwft_fifo_lvl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwft_fifo_lvl
//  Description : Self-checking bench for fwft_fifo_lvl, DEPTH=4, DWIDTH=8.
//                It uses directed steps followed by random traffic, and checks
//                the DUT against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwft_fifo_lvl;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   count;

    int            errors = 0;
    int            checks = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] last_dout = '0;
    logic          exp_ovf = 1'b0;
    logic          exp_udf = 1'b0;

    fwft_fifo_lvl #(
        .DWIDTH    (DW),
        .DEPTH     (DP),
        .AFULL_TH  (3),
        .AEMPTY_TH (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write        (write),
        .din          (din),
        .read         (read),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("dout",         32'(dout),         32'(last_dout));
        chk("count",        32'(count),        32'(sz));
        chk("full",         32'(full),         32'(sz == DP));
        chk("empty",        32'(empty),        32'(sz == 0));
        chk("almost_full",  32'(almost_full),  32'(sz >= 3));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= 1));
        chk("overflow",     32'(overflow),     32'(exp_ovf));
        chk("underflow",    32'(underflow),    32'(exp_udf));
    endtask

    task automatic model_reset();
        q.delete();
        last_dout = '0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    // Drive one cycle of requests, update the model, and check after the edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        int  sz;
        logic rd_ok, wr_ok;
        write = w;
        din   = d;
        read  = r;
        sz      = q.size();
        exp_ovf = w && (sz == DP) && !r;
        exp_udf = r && (sz == 0);
        rd_ok   = r && (sz != 0);
        wr_ok   = w && ((sz != DP) || r);
        if (rd_ok) void'(q.pop_front());
        if (wr_ok) q.push_back(d);
        if (q.size() != 0) last_dout = q[0];
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b0;

        // Single word: one-cycle fall-through, then drain
        step(1'b1, 8'hA1, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        // Fill to full, overflow attempt, drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h05, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

        // Full with simultaneous read and write
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h05, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

        // Empty with simultaneous read and write: underflow plus bypass
        step(1'b1, 8'h77, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Streaming at count 2 across pointer wrap
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'hE1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Fill to the almost-full threshold, then reset asynchronously mid-cycle
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        write = 1'b0;
        read  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        // Random traffic: write-heavy, then read-heavy, then balanced
        for (int i = 0; i < 600; i++) begin
            int wp, rp;
            wp = (i < 200) ? 75 : (i < 400) ? 30 : 50;
            rp = (i < 200) ? 30 : (i < 400) ? 75 : 50;
            step(1'($urandom_range(0, 99) < wp), 8'($urandom), 1'($urandom_range(0, 99) < rp));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
